// File: rtl/minc_run_if.sv
// Host/debug-to-controller bundle for minc_run_ctrl: run controls, breakpoint setup,
// the core's presented instruction, and the controller's enable and status.
interface minc_run_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             step;
  logic             stop;
  logic             clr;
  logic             bp_en;
  logic [7:0]       bp_addr;
  logic [7:0]       pc;
  logic [7:0]       sp;
  logic [2:0]       opcode;
  logic             core_en;
  logic [2:0]       state;
  logic [1:0]       fault;
  logic [CNT_W-1:0] icount;

  modport master (
    output start, step, stop, clr, bp_en, bp_addr, pc, sp, opcode,
    input  core_en, state, fault, icount
  );

  modport slave (
    input  start, step, stop, clr, bp_en, bp_addr, pc, sp, opcode,
    output core_en, state, fault, icount
  );
endinterface

// File: rtl/minc_run_ctrl.sv
// Run/step/breakpoint gate for the minc core: guards the presented instruction and drops core_en
// in the same cycle on a guard hit or stop (zero-latency); status outputs are registered.
module minc_run_ctrl #(
  parameter int DEPTH     = 256,
  parameter int CNT_W     = 16,
  parameter int CYC_LIMIT = 0
) (
  input  logic          CLK,
  input  logic          nRESET,
  minc_run_if.slave     io_bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_BREAK  = 3'd3,
    S_HALTED = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [7:0]       SP_MAX   = 8'(DEPTH - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(CYC_LIMIT);
  localparam bit               WD_ON    = (CYC_LIMIT != 0);

  state_t           r_state;
  logic [1:0]       r_fault;
  logic [CNT_W-1:0] r_icount;
  logic             r_skip;

  logic w_underflow;
  logic w_overflow;
  logic w_halt;
  logic w_wdog;
  logic w_bp;
  logic w_guard;
  logic w_active;
  logic w_core_en;

  always_comb begin
    w_underflow = (io_bus.opcode inside {3'b001, 3'b010, 3'b011}) && (io_bus.sp < 8'd2);
    w_overflow  = (io_bus.opcode == 3'b000) && (io_bus.sp == SP_MAX);
    w_halt      = (io_bus.opcode == 3'b100);
    w_wdog      = WD_ON && (r_icount == WD_LIMIT);
    w_bp        = io_bus.bp_en && (io_bus.pc == io_bus.bp_addr) && !r_skip;
    w_guard     = w_underflow || w_overflow || w_halt || w_wdog || w_bp;
    w_active    = (r_state == S_RUN) || (r_state == S_STEP);
    w_core_en   = w_active && !w_guard && !io_bus.stop;
  end

  assign io_bus.core_en = w_core_en;
  assign io_bus.state   = r_state;
  assign io_bus.fault   = r_fault;
  assign io_bus.icount  = r_icount;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state  <= S_IDLE;
      r_fault  <= 2'd0;
      r_icount <= '0;
      r_skip   <= 1'b0;
    end else begin
      // core_en is only ever high in RUN/STEP, so this never races the IDLE clear below
      if (w_core_en) begin
        if (r_icount != '1) r_icount <= r_icount + CNT_W'(1);
        r_skip <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (io_bus.start || io_bus.step) begin
            r_state  <= io_bus.start ? S_RUN : S_STEP;
            r_icount <= '0;
            r_skip   <= 1'b0;
          end
        end
        S_RUN, S_STEP: begin
          if (w_underflow) begin
            r_state <= S_FAULT;
            r_fault <= 2'd1;
          end else if (w_overflow) begin
            r_state <= S_FAULT;
            r_fault <= 2'd2;
          end else if (w_halt) begin
            r_state <= S_HALTED;
          end else if (w_wdog) begin
            r_state <= S_FAULT;
            r_fault <= 2'd3;
          end else if (w_bp || io_bus.stop || (r_state == S_STEP)) begin
            r_state <= S_BREAK;
          end
        end
        S_BREAK: begin
          // skip lets the instruction sitting on the breakpoint execute once on resume
          if (io_bus.start || io_bus.step) begin
            r_state <= io_bus.start ? S_RUN : S_STEP;
            r_skip  <= 1'b1;
          end
        end
        S_HALTED, S_FAULT: begin
          if (io_bus.clr) begin
            r_state <= S_IDLE;
            r_fault <= 2'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minc_run_ctrl.sv
// Directed bench for minc_run_ctrl: a tiny stack-core model runs short programs and a
// scoreboard queue holds the PCs expected to execute; a second instance exercises the watchdog.
module tb_minc_run_ctrl;
  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  always #5 CLK = ~CLK;

  minc_run_if #(.CNT_W(16)) bus ();
  minc_run_if #(.CNT_W(16)) wbus ();

  minc_run_ctrl #(.DEPTH(256), .CNT_W(16), .CYC_LIMIT(0)) dut (
    .CLK(CLK), .nRESET(nRESET), .io_bus(bus)
  );
  minc_run_ctrl #(.DEPTH(256), .CNT_W(16), .CYC_LIMIT(4)) u_wd (
    .CLK(CLK), .nRESET(nRESET), .io_bus(wbus)
  );

  localparam logic [2:0] LD = 3'b000, ADD = 3'b001, HALT = 3'b100, NOP = 3'b101;

  int         checks = 0;
  int         failures = 0;
  int         exp_pc_q[$];
  logic [2:0] prog[0:15];
  logic [7:0] cpc;
  logic [7:0] csp;
  int         wexec;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic present();
    bus.pc     = cpc;
    bus.sp     = csp;
    bus.opcode = prog[cpc[3:0]];
  endtask

  task automatic set_prog(input logic [2:0] a, b, c, d, e, input logic [7:0] sp0);
    for (int i = 0; i < 16; i++) prog[i] = HALT;
    prog[0] = a; prog[1] = b; prog[2] = c; prog[3] = d; prog[4] = e;
    cpc = 8'd0;
    csp = sp0;
    present();
  endtask

  // One clock: sample core_en mid-cycle, let the core model execute on the edge, drop pulses.
  task automatic clk1();
    logic en;
    @(negedge CLK);
    en = bus.core_en;
    if (en) chk("exec_pc", int'(cpc), (exp_pc_q.size() > 0) ? exp_pc_q.pop_front() : -1);
    @(posedge CLK);
    #1;
    if (en) begin
      case (prog[cpc[3:0]])
        3'b000:                 csp = csp + 8'd1;
        3'b001, 3'b010, 3'b011: csp = csp - 8'd1;
        default: ;
      endcase
      cpc = cpc + 8'd1;
    end
    bus.start = 1'b0;
    bus.step  = 1'b0;
    bus.stop  = 1'b0;
    bus.clr   = 1'b0;
    present();
  endtask

  task automatic run_until(input int max);
    int n = 0;
    while ((bus.state == 3'd1 || bus.state == 3'd2) && n < max) begin
      clk1();
      n++;
    end
    chk("run_bound", (bus.state == 3'd1 || bus.state == 3'd2) ? 1 : 0, 0);
  endtask

  initial begin
    bus.start = 0; bus.step = 0; bus.stop = 0; bus.clr = 0;
    bus.bp_en = 0; bus.bp_addr = 8'd0;
    wbus.start = 0; wbus.step = 0; wbus.stop = 0; wbus.clr = 0;
    wbus.bp_en = 0; wbus.bp_addr = 8'd0;
    wbus.pc = 8'd0; wbus.sp = 8'd0; wbus.opcode = NOP;
    set_prog(LD, LD, ADD, HALT, HALT, 8'd0);

    #12;
    chk("rst_state", bus.state, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_icount", bus.icount, 0);
    chk("rst_core_en", bus.core_en, 0);
    chk("rst_wd_state", wbus.state, 0);
    nRESET = 1'b1;
    @(posedge CLK); #1;

    // LD 3, LD 4, ADD, HALT
    exp_pc_q.push_back(0); exp_pc_q.push_back(1); exp_pc_q.push_back(2);
    bus.start = 1; clk1();
    run_until(20);
    chk("halt_state", bus.state, 4);
    chk("halt_icount", bus.icount, 3);
    chk("halt_pc", cpc, 3);
    chk("halt_fault", bus.fault, 0);
    chk("halt_drain", exp_pc_q.size(), 0);
    bus.clr = 1; clk1();
    chk("clr_state", bus.state, 0);

    // ADD with sp=1
    set_prog(LD, ADD, HALT, HALT, HALT, 8'd0);
    exp_pc_q.push_back(0);
    bus.start = 1; clk1();
    run_until(20);
    chk("uf_state", bus.state, 5);
    chk("uf_fault", bus.fault, 1);
    chk("uf_icount", bus.icount, 1);
    chk("uf_pc", cpc, 1);
    bus.clr = 1; clk1();
    chk("uf_clr_state", bus.state, 0);
    chk("uf_clr_fault", bus.fault, 0);

    // LD at sp=254 executes, LD at sp=255 faults
    set_prog(LD, LD, HALT, HALT, HALT, 8'd254);
    exp_pc_q.push_back(0);
    bus.start = 1; clk1();
    run_until(20);
    chk("of_state", bus.state, 5);
    chk("of_fault", bus.fault, 2);
    chk("of_icount", bus.icount, 1);
    chk("of_pc", cpc, 1);
    chk("of_sp", csp, 255);
    bus.clr = 1; clk1();

    // Breakpoint at pc=2, step over it, resume to HALT
    set_prog(LD, LD, ADD, LD, HALT, 8'd0);
    bus.bp_en = 1; bus.bp_addr = 8'd2;
    present();
    exp_pc_q.push_back(0); exp_pc_q.push_back(1);
    bus.start = 1; clk1();
    run_until(20);
    chk("bp_state", bus.state, 3);
    chk("bp_icount", bus.icount, 2);
    chk("bp_pc", cpc, 2);
    exp_pc_q.push_back(2);
    bus.step = 1; clk1();
    clk1();
    chk("step_state", bus.state, 3);
    chk("step_icount", bus.icount, 3);
    chk("step_pc", cpc, 3);
    exp_pc_q.push_back(3);
    bus.start = 1; clk1();
    run_until(20);
    chk("resume_state", bus.state, 4);
    chk("resume_icount", bus.icount, 4);
    chk("resume_drain", exp_pc_q.size(), 0);
    bus.clr = 1; clk1();
    bus.bp_en = 0;

    // start and step together from IDLE
    set_prog(LD, HALT, HALT, HALT, HALT, 8'd0);
    exp_pc_q.push_back(0);
    bus.start = 1; bus.step = 1; clk1();
    chk("both_state", bus.state, 1);
    run_until(20);
    chk("both_end_state", bus.state, 4);
    chk("both_icount", bus.icount, 1);
    bus.clr = 1; clk1();

    // stop coinciding with a breakpoint, then stop alone, then reset mid-run
    set_prog(LD, LD, LD, HALT, HALT, 8'd0);
    bus.bp_en = 1; bus.bp_addr = 8'd1;
    present();
    exp_pc_q.push_back(0);
    bus.start = 1; clk1();
    clk1();
    bus.stop = 1; #1;
    chk("stopbp_core_en", bus.core_en, 0);
    clk1();
    chk("stopbp_state", bus.state, 3);
    chk("stopbp_icount", bus.icount, 1);
    clk1();
    chk("stopbp_single", bus.state, 3);
    bus.bp_en = 0;
    exp_pc_q.push_back(1);
    bus.start = 1; clk1();
    clk1();
    chk("run_pc", cpc, 2);
    bus.stop = 1; #1;
    chk("stop_core_en", bus.core_en, 0);
    clk1();
    chk("stop_state", bus.state, 3);
    chk("stop_icount", bus.icount, 2);
    chk("stop_pc", cpc, 2);
    bus.start = 1; clk1();
    chk("pre_rst_core_en", bus.core_en, 1);
    nRESET = 1'b0; #1;
    chk("arst_core_en", bus.core_en, 0);
    chk("arst_state", bus.state, 0);
    chk("arst_icount", bus.icount, 0);
    clk1();
    nRESET = 1'b1;
    chk("arst_pc", cpc, 2);
    chk("arst_drain", exp_pc_q.size(), 0);
    @(posedge CLK); #1;

    // Watchdog instance on an endless NOP stream
    wexec = 0;
    wbus.start = 1;
    @(posedge CLK); #1;
    wbus.start = 0;
    for (int i = 0; i < 20 && wbus.state == 3'd1; i++) begin
      @(negedge CLK);
      if (wbus.core_en) wexec++;
      @(posedge CLK); #1;
    end
    chk("wd_state", wbus.state, 5);
    chk("wd_fault", wbus.fault, 3);
    chk("wd_icount", wbus.icount, 4);
    chk("wd_exec", wexec, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/minc_run_ctrl.md
# minc_run_ctrl

Run/step/breakpoint controller for the minc stack core. It gates the core's execute enable. Before each instruction executes, it checks the opcode, PC and stack pointer, and stops the core on HALT, stack underflow/overflow, a PC breakpoint, a host stop request or a cycle watchdog. The core never executes a HALT opcode or a stack-corrupting instruction. The block sits between the host/debug interface and the core and also reports status and an executed-instruction count.

## Interface
- DEPTH, 256: stack entries; sp range 0..DEPTH-1
- CNT_W, 16: width of the executed-instruction counter
- CYC_LIMIT, 0: watchdog limit in executed instructions; 0 disables the watchdog
- CLK  in  1  clock, rising edge
- nRESET  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: run
- step  in  1  one-cycle pulse: execute exactly one instruction
- stop  in  1  one-cycle pulse: pause a running core
- clr  in  1  one-cycle pulse: return HALTED/FAULT to IDLE
- bp_en  in  1  breakpoint enable
- bp_addr  in  8  breakpoint PC
- pc  in  8  core PC; the instruction presented this cycle
- sp  in  8  core stack pointer
- opcode  in  3  instruction[10:8] of the presented instruction
- core_en  out  1  core executes the presented instruction at the next rising edge when 1
- state  out  3  IDLE=0, RUN=1, STEP=2, BREAK=3, HALTED=4, FAULT=5
- fault  out  2  0 none, 1 underflow, 2 overflow, 3 watchdog
- icount  out  CNT_W  executed instructions since the last start/step from IDLE; saturates at all-ones

## Operation
- Guard conditions are evaluated combinationally on the presented instruction, in this priority order:
  - underflow: opcode in {001,010,011} and sp<2
  - overflow: opcode==000 and sp==DEPTH-1
  - halt: opcode==100
  - watchdog: CYC_LIMIT!=0 and icount==CYC_LIMIT
  - breakpoint: bp_en, pc==bp_addr and skip==0
- Opcodes 101..111 are NOPs to the controller and pass unguarded.
- core_en = (state==RUN or state==STEP) and no guard hit and no stop this cycle. core_en is combinational from the registered state and the inputs.
- State transitions:
  - IDLE: start → RUN; step → STEP. Both clear icount. start wins if start and step arrive together. stop and clr are ignored.
  - RUN: underflow/overflow/watchdog → FAULT with fault code latched. Halt → HALTED. Breakpoint or stop → BREAK. Otherwise stay in RUN.
  - STEP: on a guard hit, take the same targets as RUN. Otherwise the one enabled cycle executes and the next state is BREAK. stop in STEP → BREAK with no execution.
  - BREAK: start → RUN; step → STEP. Both set skip. icount is kept.
  - HALTED, FAULT: clr → IDLE, fault cleared. All other inputs are ignored.
- skip: set on leaving BREAK; cleared at the first edge where core_en=1. A breakpoint instruction therefore executes once on resume.
- icount: increments at each edge where core_en=1; saturates.
- clr does not touch the core. Core PC/SP are reset only by the core's own nRESET.

## Timing
- Reset (asynchronous, nRESET low): state=IDLE, fault=0, icount=0, skip=0, so core_en=0 immediately.
- Zero-cycle stop latency: a guard hit or a stop pulse forces core_en=0 in the same cycle, and the presented instruction is not executed.
- start/step sampled at edge N: state changes at N. The first enabled instruction edge is N+1.
- STEP executes exactly one instruction, so icount rises by 1 unless a guard hits.
- Status outputs (state, fault, icount) are registered.
- nRESET asserted mid-RUN: core_en drops asynchronously. The instruction at that edge is not counted.

## Test plan
- Program LD 3, LD 4, ADD, HALT; pulse start → core_en high for 3 cycles, state=HALTED, icount=3, core_en=0 while opcode=100.
- ADD with sp=1 in RUN → core_en=0 that cycle, state=FAULT, fault=1; clr → state=IDLE, fault=0.
- LD with sp=DEPTH-1 → fault=2, no execute edge; LD with sp=DEPTH-2 executes normally.
- bp_en=1, bp_addr=2 on a 5-instruction program: start → BREAK with pc=2, icount=2; step → pc=3, icount=3, state=BREAK; start → runs to HALT.
- CYC_LIMIT=4 on an endless NOP loop (opcode 101) → FAULT, fault=3, icount=4.
- Simultaneous start+step in IDLE → RUN. stop on the same cycle as a breakpoint → BREAK, single transition. nRESET pulse mid-RUN → IDLE, icount=0.
